// File: rtl/bits_stream_buffer.sv
// Bit-granular stream buffer between the fetch controller and the BITS decoder.
// 128-bit words are loaded left-aligned and served as 1..16 bit MSB-first fields.
module bits_stream_buffer #(
    parameter int BUF_BITS = 256,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             resetB,
    input  logic [127:0]     instruction_word,
    input  logic [15:0]      instruction_valid_bytes,
    input  logic             mem_ack_b,
    input  logic             done_reading_memory,
    output logic             mem_req_b,
    input  logic             take_req,
    input  logic [4:0]       take_len,
    output logic             take_ready,
    output logic [15:0]      take_data,
    output logic             take_valid,
    output logic             take_err,
    output logic [8:0]       fill_count,
    output logic [CNT_W-1:0] bits_consumed,
    output logic             stream_end
);

    typedef enum logic [1:0] {F_IDLE, F_REQ, F_HOLD, F_EXH} fill_state_e;

    fill_state_e         state_q, state_d;
    logic [BUF_BITS-1:0] buf_q, buf_d;
    logic [8:0]          fill_q, fill_d;
    logic [CNT_W-1:0]    cons_q, cons_d;
    logic                mem_req_b_q, mem_req_b_d;
    logic [15:0]         take_data_q, take_data_d;
    logic                take_valid_q, take_valid_d;
    logic                take_err_q, take_err_d;
    logic                take_ready_q, take_ready_d;
    logic                stream_end_q, stream_end_d;

    logic                len_bad;
    logic                accept;
    logic [8:0]          taken;
    logic [8:0]          fill_after;
    logic [8:0]          load_bits;
    logic [4:0]          byte_cnt;
    logic [127:0]        word_masked;
    logic [BUF_BITS-1:0] buf_taken;

    // Only the leading load_bits of the word survive, so stale bytes never leak in.
    always_comb begin
        byte_cnt = '0;
        for (int i = 0; i < 16; i++) begin
            byte_cnt = byte_cnt + {4'b0, instruction_valid_bytes[i]};
        end
        load_bits   = {1'b0, byte_cnt, 3'b000};
        word_masked = instruction_word & ~({128{1'b1}} >> load_bits);
    end

    always_comb begin
        len_bad      = (take_len == 5'd0) || (take_len > 5'd16);
        accept       = take_req && !len_bad && ({4'b0, take_len} <= fill_q);
        taken        = accept ? {4'b0, take_len} : 9'd0;
        fill_after   = fill_q - taken;
        buf_taken    = buf_q << taken;
        take_valid_d = accept;
        take_err_d   = take_req && (len_bad || (!accept && state_q == F_EXH));
        take_data_d  = accept ? (buf_q[BUF_BITS-1 -: 16] >> (5'd16 - take_len))
                              : take_data_q;
        cons_d       = cons_q + {{(CNT_W-9){1'b0}}, taken};
    end

    // Loads land directly behind whatever survives this cycle's take.
    always_comb begin
        state_d     = state_q;
        mem_req_b_d = 1'b1;
        buf_d       = buf_taken;
        fill_d      = fill_after;
        unique case (state_q)
            F_IDLE: begin
                if (fill_after <= 9'd128) begin
                    state_d     = F_REQ;
                    mem_req_b_d = 1'b0;
                end
            end
            F_REQ: begin
                if (!mem_ack_b) begin
                    buf_d  = buf_taken
                           | ({word_masked, {(BUF_BITS-128){1'b0}}} >> fill_after);
                    fill_d = fill_after + load_bits;
                    if (done_reading_memory || byte_cnt < 5'd16) begin
                        state_d = F_EXH;
                    end else begin
                        state_d = F_HOLD;
                    end
                end else begin
                    mem_req_b_d = 1'b0;
                end
            end
            F_HOLD:  state_d = F_IDLE;
            F_EXH:   state_d = F_EXH;
            default: state_d = F_IDLE;
        endcase
        take_ready_d = (fill_d >= 9'd16) || (state_d == F_EXH);
        stream_end_d = (state_d == F_EXH) && (fill_d == 9'd0);
    end

    always_ff @(posedge clk) begin
        if (!resetB) begin
            state_q      <= F_IDLE;
            buf_q        <= '0;
            fill_q       <= '0;
            cons_q       <= '0;
            mem_req_b_q  <= 1'b1;
            take_data_q  <= '0;
            take_valid_q <= 1'b0;
            take_err_q   <= 1'b0;
            take_ready_q <= 1'b0;
            stream_end_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            buf_q        <= buf_d;
            fill_q       <= fill_d;
            cons_q       <= cons_d;
            mem_req_b_q  <= mem_req_b_d;
            take_data_q  <= take_data_d;
            take_valid_q <= take_valid_d;
            take_err_q   <= take_err_d;
            take_ready_q <= take_ready_d;
            stream_end_q <= stream_end_d;
        end
    end

    assign mem_req_b     = mem_req_b_q;
    assign take_data     = take_data_q;
    assign take_valid    = take_valid_q;
    assign take_err      = take_err_q;
    assign take_ready    = take_ready_q;
    assign fill_count    = fill_q;
    assign bits_consumed = cons_q;
    assign stream_end    = stream_end_q;

endmodule

// File: tb/tb_bits_stream_buffer.sv
// Bench for bits_stream_buffer: bit-queue reference model, response scoreboard
// and a separate monitor, driven by directed scenarios and random traffic.
module tb_bits_stream_buffer;

    logic         clk = 1'b0;
    logic         resetB = 1'b0;
    logic [127:0] instruction_word = '0;
    logic [15:0]  instruction_valid_bytes = '0;
    logic         mem_ack_b = 1'b1;
    logic         done_reading_memory = 1'b0;
    logic         mem_req_b;
    logic         take_req = 1'b0;
    logic [4:0]   take_len = '0;
    logic         take_ready;
    logic [15:0]  take_data;
    logic         take_valid;
    logic         take_err;
    logic [8:0]   fill_count;
    logic [15:0]  bits_consumed;
    logic         stream_end;

    bits_stream_buffer dut (
        .clk                     (clk),
        .resetB                  (resetB),
        .instruction_word        (instruction_word),
        .instruction_valid_bytes (instruction_valid_bytes),
        .mem_ack_b               (mem_ack_b),
        .done_reading_memory     (done_reading_memory),
        .mem_req_b               (mem_req_b),
        .take_req                (take_req),
        .take_len                (take_len),
        .take_ready              (take_ready),
        .take_data               (take_data),
        .take_valid              (take_valid),
        .take_err                (take_err),
        .fill_count              (fill_count),
        .bits_consumed           (bits_consumed),
        .stream_end              (stream_end)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          err;
        logic [15:0] data;
        int          due;
    } resp_t;

    resp_t       sbq[$];
    bit          mq[$];
    logic [15:0] mcons = '0;
    int          mphase = 0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    resp_t       mon_r;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h cyc=%0d", nm, act, exp, cyc);
        end
    endtask

    task automatic push_resp(input bit e, input logic [15:0] d);
        resp_t r;
        r.err  = e;
        r.data = d;
        r.due  = cyc + 1;
        sbq.push_back(r);
    endtask

    // Reference: the buffer is a plain queue of bits; phase 0 idle, 1 waiting
    // for ack, 2 one-cycle pause after a word, 3 source exhausted.
    task automatic model_step();
        logic [15:0] v;
        int          cnt;
        if (!resetB) begin
            mq.delete();
            mcons  = '0;
            mphase = 0;
            return;
        end
        if (take_req) begin
            if (take_len == 5'd0 || take_len > 5'd16) begin
                push_resp(1'b1, 16'h0);
            end else if (int'(take_len) <= mq.size()) begin
                v = '0;
                for (int i = 0; i < int'(take_len); i++) v = {v[14:0], mq.pop_front()};
                mcons += 16'(take_len);
                push_resp(1'b0, v);
            end else if (mphase == 3) begin
                push_resp(1'b1, 16'h0);
            end
        end
        case (mphase)
            0: if (mq.size() <= 128) mphase = 1;
            1: if (!mem_ack_b) begin
                cnt = 0;
                for (int i = 0; i < 16; i++) cnt += int'(instruction_valid_bytes[i]);
                for (int i = 0; i < 8 * cnt; i++) mq.push_back(instruction_word[127-i]);
                mphase = (done_reading_memory || cnt < 16) ? 3 : 2;
            end
            2: mphase = 0;
            default: ;
        endcase
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk("fill_count", 32'(fill_count), 32'(mq.size()));
        chk("bits_consumed", 32'(bits_consumed), 32'(mcons));
        chk("mem_req_b", 32'(mem_req_b), (mphase == 1) ? 32'd0 : 32'd1);
        chk("stream_end", 32'(stream_end), 32'(mphase == 3 && mq.size() == 0));
        chk("take_ready", 32'(take_ready), 32'(mq.size() >= 16 || mphase == 3));
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a field or an error.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].due < cyc) begin
            checks++;
            errors++;
            $display("FAIL missing_resp due=%0d cyc=%0d", sbq[0].due, cyc);
            void'(sbq.pop_front());
        end
        if (take_valid || take_err) begin
            checks++;
            if (sbq.size() == 0 || sbq[0].due != cyc) begin
                errors++;
                $display("FAIL unexpected_resp valid=%0b err=%0b cyc=%0d",
                         take_valid, take_err, cyc);
            end else begin
                mon_r = sbq.pop_front();
                if (take_err != mon_r.err || take_valid == mon_r.err ||
                    (!mon_r.err && take_data !== mon_r.data)) begin
                    errors++;
                    $display("FAIL take_resp actual v=%0b e=%0b d=%0h expected e=%0b d=%0h",
                             take_valid, take_err, take_data, mon_r.err, mon_r.data);
                end
            end
        end
    end

    task automatic idle_in();
        take_req                = 1'b0;
        take_len                = 5'd0;
        mem_ack_b               = 1'b1;
        done_reading_memory     = 1'b0;
        instruction_valid_bytes = 16'h0;
        instruction_word        = '0;
    endtask

    task automatic do_reset();
        resetB = 1'b0;
        for (int k = 0; k < 3; k++) begin
            take_req  = 1'b1;
            take_len  = 5'($urandom_range(1, 16));
            mem_ack_b = 1'($urandom % 2);
            instruction_valid_bytes = 16'hFFFF;
            step();
            chk("rst_take_data", 32'(take_data), 32'd0);
            chk("rst_take_valid", 32'(take_valid), 32'd0);
        end
        idle_in();
        resetB = 1'b1;
        step();
        chk("first_req", 32'(mem_req_b), 32'd0);
    endtask

    task automatic wait_req();
        idle_in();
        for (int k = 0; k < 16 && mphase != 1; k++) step();
        chk("req_wait", 32'(mem_req_b), 32'd0);
    endtask

    task automatic ack_word(input logic [127:0] w, input logic [15:0] vb, input bit dn);
        mem_ack_b               = 1'b0;
        instruction_word        = w;
        instruction_valid_bytes = vb;
        done_reading_memory     = dn;
        step();
        idle_in();
    endtask

    task automatic take(input int len);
        take_req = 1'b1;
        take_len = 5'(len);
        step();
        take_req = 1'b0;
    endtask

    task automatic rand_cycles(input int n, input int done_pct);
        int kb;
        for (int k = 0; k < n; k++) begin
            take_req = ($urandom % 100) < 60;
            if ($urandom % 100 < 85) take_len = 5'($urandom_range(1, 16));
            else if ($urandom % 2 == 1) take_len = 5'd0;
            else take_len = 5'($urandom_range(17, 31));
            instruction_word = {$urandom, $urandom, $urandom, $urandom};
            kb = $urandom_range(0, 15);
            instruction_valid_bytes = ($urandom % 100 < 85) ? 16'hFFFF : ~(16'hFFFF >> kb);
            mem_ack_b = (mphase == 1) ? 1'($urandom % 2) : (($urandom % 10) != 0);
            done_reading_memory = ($urandom % 100) < done_pct;
            step();
        end
        idle_in();
    endtask

    logic [127:0] w3;
    int           need;
    int           len;
    bit           took;

    initial begin
        idle_in();
        do_reset();

        ack_word(128'hD2FE28 << 104, 16'hFFFF, 1'b0);
        chk("load_fill", 32'(fill_count), 32'd128);
        take(3);
        chk("field0", 32'(take_data), 32'h6);
        take(3);
        chk("field1", 32'(take_data), 32'h4);
        take(5);
        chk("field2", 32'(take_data), 32'h17);
        chk("consumed11", 32'(bits_consumed), 32'd11);
        take(0);
        chk("len0_err", 32'(take_err), 32'd1);
        take(17);
        chk("len17_err", 32'(take_err), 32'd1);
        chk("illegal_cons", 32'(bits_consumed), 32'd11);
        chk("illegal_fill", 32'(fill_count), 32'd117);

        do_reset();
        ack_word({$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 1'b0);
        wait_req();
        ack_word({$urandom, $urandom, $urandom, $urandom}, 16'hFFFF, 1'b0);
        chk("fill256", 32'(fill_count), 32'd256);
        step();
        for (int k = 0; k < 7; k++) take(16);
        chk("thr_fill144", 32'(fill_count), 32'd144);
        chk("thr_noreq", 32'(mem_req_b), 32'd1);
        take(16);
        chk("thr_fill128", 32'(fill_count), 32'd128);
        chk("thr_req", 32'(mem_req_b), 32'd0);
        w3 = {$urandom, $urandom, $urandom, $urandom};
        ack_word(w3, 16'hFFFF, 1'b0);
        chk("thr_fill_full", 32'(fill_count), 32'd256);
        for (int k = 0; k < 8; k++) take(16);
        take(16);
        chk("append_order", 32'(take_data), 32'(w3[127:112]));

        do_reset();
        ack_word({$urandom, $urandom, $urandom, $urandom}, 16'hF000, 1'b1);
        chk("part_fill", 32'(fill_count), 32'd32);
        take(16);
        take(16);
        chk("part_end", 32'(stream_end), 32'd1);
        take(1);
        chk("part_err", 32'(take_err), 32'd1);

        for (int ep = 0; ep < 6; ep++) begin
            do_reset();
            rand_cycles(400, 3);
        end

        do_reset();
        for (int k = 0; k < 20000 && mcons != 16'hFFF8; k++) begin
            need = 32'hFFF8 - int'(mcons);
            len = (need > 16) ? 16 : need;
            take_req = mq.size() >= len;
            take_len = 5'(len);
            mem_ack_b = (mphase != 1);
            instruction_word = {$urandom, $urandom, $urandom, $urandom};
            instruction_valid_bytes = 16'hFFFF;
            step();
        end
        chk("wrap_pre", 32'(bits_consumed), 32'hFFF8);
        took = 1'b0;
        for (int k = 0; k < 20 && !took; k++) begin
            take_req = mq.size() >= 16;
            take_len = 5'd16;
            took = take_req;
            mem_ack_b = (mphase != 1);
            step();
        end
        chk("wrap", 32'(bits_consumed), 32'h0008);

        idle_in();
        for (int k = 0; k < 3; k++) step();
        chk("sb_empty", 32'(sbq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
